// File: rtl/mat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mat_pkg
// Description : Shared types and constants for the matrix fetch/unpack stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mat_pkg;

    localparam int WORD_W       = 64;
    localparam int BYTE_W       = 8;
    localparam int DEFAULT_ROWS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        UNPACK    = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : word_unpacker
// Description : Holds one memory word and presents its bytes MSB-first,
//               advancing only when the consumer accepts the current byte.
// Revision    : 1.0 - initial release
// ============================================================================
module word_unpacker
    import mat_pkg::*;
#(
    parameter int BYTE_WIDTH = BYTE_W,
    parameter int NUM_BYTES  = WORD_W / BYTE_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_load,
    input  logic [BYTE_WIDTH*NUM_BYTES-1:0] i_data,
    input  logic                            i_ready,
    output logic [BYTE_WIDTH-1:0]           o_byte,
    output logic                            o_valid,
    output logic                            o_last
);

    localparam int c_WORD_W = BYTE_WIDTH * NUM_BYTES;
    localparam int c_IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic [c_WORD_W-1:0] r_hold;
    logic [c_WORD_W-1:0] w_shifted;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_hold  <= i_data;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            if (o_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // After the last byte the index parks, so the output byte stays stable.
    assign w_shifted = r_hold << (BYTE_WIDTH * r_idx);
    assign o_byte    = w_shifted[c_WORD_W-1 -: BYTE_WIDTH];
    assign o_last    = (r_idx == c_IDX_W'(NUM_BYTES - 1));
    assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/mat_fetch_unpack.sv
`default_nettype none
// ============================================================================
// Module      : mat_fetch_unpack
// Description : Avalon-MM read master that fetches the B vector and A rows and
//               unpacks each word into the B / A-row FIFOs. Optional byte
//               checksum built when MAT_FETCH_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_fetch_unpack
    import mat_pkg::*;
#(
    parameter int          DATA_WIDTH = BYTE_W,
    parameter int          NUM_ROWS   = DEFAULT_ROWS,
    parameter int          WORD_BYTES = WORD_W / BYTE_W,
    parameter logic [31:0] BASE_ADDR  = 32'd0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic [31:0]                      address,
    output logic                             read,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] readdata,
    input  logic                             readdatavalid,
    input  logic                             waitrequest,
    output logic [DATA_WIDTH-1:0]            fifo_data,
    output logic                             wrreq_b,
    output logic [NUM_ROWS-1:0]              wrreq_a,
    input  logic                             wrfull_b,
    input  logic [NUM_ROWS-1:0]              wrfull_a,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      checksum
);

    localparam int c_IDX_W = $clog2(NUM_ROWS + 1);

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_word_idx;
    logic                w_accept;
    logic                w_load;
    logic                w_sel_b;
    logic [NUM_ROWS-1:0] w_row_sel;
    logic                w_target_full;
    logic                w_write;
    logic [DATA_WIDTH-1:0] w_byte;
    logic                w_valid;
    logic                w_last;
    logic                w_start_ok;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept   = (r_state == REQ) && !waitrequest;
    // A zero-latency slave may return data in the very cycle it accepts.
    assign w_load     = readdatavalid && (w_accept || (r_state == WAIT_DATA));

    assign w_sel_b = (r_word_idx == '0);

    generate
        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row_sel
            assign w_row_sel[r] = (r_word_idx == c_IDX_W'(r + 1));
        end
    endgenerate

    assign w_target_full = w_sel_b ? wrfull_b : |(wrfull_a & w_row_sel);
    assign w_write       = (r_state == UNPACK) && w_valid && !w_target_full;
    assign wrreq_b       = w_write && w_sel_b;
    assign wrreq_a       = {NUM_ROWS{w_write}} & w_row_sel;
    assign fifo_data     = w_byte;

    word_unpacker #(
        .BYTE_WIDTH (DATA_WIDTH),
        .NUM_BYTES  (WORD_BYTES)
    ) u_unpacker (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (readdata),
        .i_ready (w_write),
        .o_byte  (w_byte),
        .o_valid (w_valid),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word_idx <= '0;
            address    <= 32'd0;
            read       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= REQ;
                        r_word_idx <= '0;
                        address    <= BASE_ADDR;
                        read       <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                REQ: begin
                    if (w_accept) begin
                        read    <= 1'b0;
                        r_state <= readdatavalid ? UNPACK : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (readdatavalid) begin
                        r_state <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (w_write && w_last) begin
                        if (r_word_idx == c_IDX_W'(NUM_ROWS)) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                            address    <= BASE_ADDR + 32'(r_word_idx) + 32'd1;
                            read       <= 1'b1;
                            r_state    <= REQ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MAT_FETCH_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= 16'd0;
        end else if (w_start_ok) begin
            r_checksum <= 16'd0;
        end else if (w_write) begin
            r_checksum <= r_checksum + 16'(fifo_data);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mat_fetch_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_fetch_unpack
// Description : Self-checking bench for mat_fetch_unpack with an Avalon slave
//               model, FIFO-full injection and a byte-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_fetch_unpack;

    localparam logic [31:0] c_BASE = 32'h0000_0100;
    localparam int          c_ROWS = 8;
    localparam int          c_WORDS = c_ROWS + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] address;
    logic        read;
    logic [63:0] readdata = 64'd0;
    logic        readdatavalid = 1'b0;
    logic        waitrequest = 1'b0;
    logic [7:0]  fifo_data;
    logic        wrreq_b;
    logic [7:0]  wrreq_a;
    logic        wrfull_b = 1'b0;
    logic [7:0]  wrfull_a = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    mat_fetch_unpack #(
        .DATA_WIDTH (8),
        .NUM_ROWS   (c_ROWS),
        .WORD_BYTES (8),
        .BASE_ADDR  (c_BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .address       (address),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .fifo_data     (fifo_data),
        .wrreq_b       (wrreq_b),
        .wrreq_a       (wrreq_a),
        .wrfull_b      (wrfull_b),
        .wrfull_a      (wrfull_a),
        .busy          (busy),
        .done          (done),
        .checksum      (checksum)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Environment state shared between the slave/monitor and the sequence
    logic [63:0] mem [0:c_WORDS-1];
    int          cyc = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          pend_dly = 0;
    int          lat = 1;
    int          p_stall = 0;
    int          p_full = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    bit          full_mode = 1'b0;
    bit          full_now = 1'b0;
    int          full_hold = 0;
    bit          noise = 1'b0;
    logic [11:0] cap [$];
    int          first_read_cyc = -1;
    int          done_cyc = -1;
    int          read4_cnt = 0;
    int          mon_tgt;

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        logic [31:0] idx;
        idx = a - c_BASE;
        if (idx < 32'(c_WORDS)) return mem[idx[3:0]];
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    function automatic int count_tgt(input int t);
        int n = 0;
        foreach (cap[i]) if (int'(cap[i][11:8]) == t) n++;
        return n;
    endfunction

    // Slave and FIFO flags change on the falling edge; writes are sampled 1ns before the rising edge
    always @(negedge clk) begin
        cyc++;
        readdatavalid = 1'b0;
        waitrequest   = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (pend_dly == 0) begin
                    readdatavalid = 1'b1;
                    readdata      = mem_rd(pend_addr);
                    pend          = 1'b0;
                end else begin
                    pend_dly--;
                end
            end
            if (read) begin
                if (address == stall_addr && stall_left > 0) begin
                    waitrequest = 1'b1;
                    stall_left--;
                end else if (int'($urandom_range(99)) < p_stall) begin
                    waitrequest = 1'b1;
                end
                if (!waitrequest) begin
                    if (lat == 0) begin
                        readdatavalid = 1'b1;
                        readdata      = mem_rd(address);
                    end else begin
                        pend      = 1'b1;
                        pend_addr = address;
                        pend_dly  = lat - 1;
                    end
                end
            end else if (noise && !busy && !pend) begin
                readdatavalid = 1'($urandom_range(1));
                readdata      = {$urandom(), $urandom()};
            end
        end
        wrfull_b = (int'($urandom_range(99)) < p_full);
        for (int r = 0; r < c_ROWS; r++) wrfull_a[r] = (int'($urandom_range(99)) < p_full);
        full_now = 1'b0;
        if (full_mode && count_tgt(3) == 3 && full_hold < 3) begin
            wrfull_a[2] = 1'b1;
            full_hold++;
            full_now = 1'b1;
        end
        #4;
        if (read && first_read_cyc < 0) first_read_cyc = cyc;
        if (read && address == c_BASE + 32'd4) read4_cnt++;
        if (done && first_read_cyc >= 0 && done_cyc < 0) done_cyc = cyc;
        if (full_now) begin
            check("full_hold_wrreq", wrreq_a[2], 1'b0);
            check("full_hold_data", fifo_data, 8'h34);
        end
        if (wrreq_b || |wrreq_a) begin
            mon_tgt = 0;
            if (!wrreq_b) for (int r = 0; r < c_ROWS; r++) if (wrreq_a[r]) mon_tgt = r + 1;
            check("one_wrreq", $countones({wrreq_b, wrreq_a}), 1);
            check("write_while_full", (mon_tgt == 0) ? wrfull_b : wrfull_a[mon_tgt-1], 1'b0);
            cap.push_back({4'(mon_tgt), fifo_data});
        end
    end

    task automatic check_all_zero(input string pfx);
        check({pfx, "_address"}, address, 0);
        check({pfx, "_read"}, read, 0);
        check({pfx, "_fifo_data"}, fifo_data, 0);
        check({pfx, "_wrreq_b"}, wrreq_b, 0);
        check({pfx, "_wrreq_a"}, wrreq_a, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_checksum"}, checksum, 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        cap.delete();
        first_read_cyc = -1;
        done_cyc       = -1;
        read4_cnt      = 0;
        full_hold      = 0;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cyc < 0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", done_cyc >= 0, 1);
    endtask

    // Reference: word w goes to target w (0 = B, k = A row k-1), bytes MSB first
    task automatic verify(input int exp_cyc);
        logic [11:0] exp_q [$];
        logic [63:0] b;
        int          sum = 0;
        for (int w = 0; w < c_WORDS; w++) begin
            for (int i = 0; i < 8; i++) begin
                b = (mem[w] >> (8 * (7 - i))) & 64'hFF;
                exp_q.push_back({4'(w), 8'(b)});
                sum += int'(b);
            end
        end
        check("byte_count", cap.size(), exp_q.size());
        foreach (exp_q[i]) if (i < cap.size()) check($sformatf("byte[%0d]", i), cap[i], exp_q[i]);
        if (exp_cyc > 0) check("load_cycles", done_cyc - first_read_cyc, exp_cyc);
`ifdef MAT_FETCH_CHECKSUM_EN
        check("checksum", checksum, sum & 16'hFFFF);
`else
        check("checksum", checksum, 0);
`endif
        check("busy_in_done", busy, 0);
        check("done_flag", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        repeat (3) @(negedge clk);
        #4 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < c_WORDS; w++)
            for (int i = 0; i < 8; i++)
                mem[w][63-8*i -: 8] = 8'((w << 4) + i + 1);

        // Baseline load with an ignored start pulse mid-load
        do_start();
        repeat (30) @(negedge clk);
        check("busy_mid_load", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        verify(90);

        // Stray readdatavalid while done must not write anything
        noise = 1'b1;
        n = cap.size();
        repeat (12) @(negedge clk);
        noise = 1'b0;
        check("noise_ignored", cap.size(), n);
        check("done_held", done, 1);

        // Restart from DONE
        do_start();
        check("done_cleared", done, 0);
        check("busy_set", busy, 1);
        wait_done();
        verify(90);

        // Three waitrequest cycles on word 4
        stall_addr = c_BASE + 32'd4;
        stall_left = 3;
        do_start();
        wait_done();
        verify(93);
        check("stall_read_cycles", read4_cnt, 4);
        stall_addr = 32'hFFFF_FFFF;

        // A[2] full while byte 3 of word 3 is pending
        full_mode = 1'b1;
        do_start();
        wait_done();
        verify(93);
        check("full_hold_cycles", full_hold, 3);
        full_mode = 1'b0;

        // Reset during unpack of word 5, then a fresh zero-latency load
        do_start();
        k = 0;
        while (count_tgt(5) < 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reached_word5", count_tgt(5) >= 2, 1);
        @(negedge clk);
        rst = 1'b1;
        #4 check_all_zero("midload_reset");
        @(negedge clk);
        rst = 1'b0;
        n = cap.size();
        repeat (20) @(negedge clk);
        check("no_write_after_reset", cap.size(), n);
        check("idle_after_reset", {busy, done}, 2'b00);
        lat = 0;
        do_start();
        wait_done();
        verify(81);

        // Randomized loads
        for (int t = 0; t < 6; t++) begin
            for (int w = 0; w < c_WORDS; w++) mem[w] = {$urandom(), $urandom()};
            lat     = int'($urandom_range(3));
            p_stall = int'($urandom_range(40));
            p_full  = int'($urandom_range(40));
            noise   = 1'b1;
            do_start();
            wait_done();
            verify(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
